// File: rtl/cmos_capture.sv
// CMOS sensor parallel-bus receiver: frames vsync/href bytes into RGB565 pixels
// with coordinates, discarding settling frames after reset.
module cmos_capture #(
    parameter int unsigned COL         = 1024,
    parameter int unsigned ROW         = 720,
    parameter int unsigned SKIP_FRAMES = 10
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        cmos_vsyn,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    input  logic        capture_en,
    input  logic        fifo_full,
    output logic [15:0] pix_data,
    output logic        pix_wr,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_err,
    output logic        overflow
);

    localparam int unsigned SKW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [SKW-1:0] SKIP_MAX = SKW'(SKIP_FRAMES);
    localparam logic [10:0]    COL_X    = 11'(COL);
    localparam logic [9:0]     ROW_Y    = 10'(ROW);

    typedef enum logic [1:0] {IDLE, VBLANK, SKIP, ACTIVE} state_t;

    state_t         state_q, state_d;
    logic           vsyn_q, href_q, vsyn_dly_q, href_dly_q;
    logic [7:0]     data_q;
    logic [SKW-1:0] skip_cnt_q, skip_cnt_d;
    logic           phase_q, phase_d;
    logic [7:0]     hi_q, hi_d;
    logic [10:0]    x_q, x_d;
    logic [9:0]     y_q, y_d;
    logic [15:0]    pix_data_q, pix_data_d;
    logic           pix_wr_q, pix_wr_d;
    logic [10:0]    pix_x_q, pix_x_d;
    logic [9:0]     pix_y_q, pix_y_d;
    logic           frame_start_q, frame_start_d;
    logic           frame_done_q, frame_done_d;
    logic           line_err_q, line_err_d;
    logic           overflow_q, overflow_d;

    logic vs_fall, vs_rise, href_rise, cur_phase;

    assign vs_fall   = vsyn_dly_q & ~vsyn_q;
    assign vs_rise   = ~vsyn_dly_q & vsyn_q;
    assign href_rise = href_q & ~href_dly_q;
    // A new line always starts on the hi byte, even after a truncated line.
    assign cur_phase = href_rise ? 1'b0 : phase_q;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            vsyn_q        <= 1'b0;
            href_q        <= 1'b0;
            data_q        <= '0;
            vsyn_dly_q    <= 1'b0;
            href_dly_q    <= 1'b0;
            state_q       <= IDLE;
            skip_cnt_q    <= '0;
            phase_q       <= 1'b0;
            hi_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            pix_data_q    <= '0;
            pix_wr_q      <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            vsyn_q        <= cmos_vsyn;
            href_q        <= cmos_href;
            data_q        <= cmos_data;
            vsyn_dly_q    <= vsyn_q;
            href_dly_q    <= href_q;
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_data_q    <= pix_data_d;
            pix_wr_q      <= pix_wr_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        skip_cnt_d    = skip_cnt_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        x_d           = x_q;
        y_d           = y_q;
        pix_data_d    = pix_data_q;
        pix_wr_d      = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = line_err_q;
        overflow_d    = overflow_q;

        // Line-count check lands one cycle after the frame_done pulse.
        if (frame_done_q && (y_q != ROW_Y)) line_err_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (vsyn_q) state_d = VBLANK;
            end
            VBLANK: begin
                if (vs_fall) begin
                    if (skip_cnt_q < SKIP_MAX) begin
                        state_d    = SKIP;
                        skip_cnt_d = skip_cnt_q + 1'b1;
                    end else if (!capture_en) begin
                        state_d = SKIP;
                    end else begin
                        state_d       = ACTIVE;
                        frame_start_d = 1'b1;
                        line_err_d    = 1'b0;
                        overflow_d    = 1'b0;
                        x_d           = '0;
                        y_d           = '0;
                        phase_d       = 1'b0;
                    end
                end
            end
            SKIP: begin
                if (vs_rise) state_d = VBLANK;
            end
            ACTIVE: begin
                if (vs_rise) begin
                    state_d      = VBLANK;
                    frame_done_d = 1'b1;
                end else if (!vsyn_q) begin
                    if (href_q) begin
                        if (!cur_phase) begin
                            hi_d    = data_q;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if ((x_q < COL_X) && (y_q < ROW_Y)) begin
                                if (fifo_full) begin
                                    overflow_d = 1'b1;
                                end else begin
                                    pix_wr_d   = 1'b1;
                                    pix_data_d = {hi_q, data_q};
                                    pix_x_d    = x_q;
                                    pix_y_d    = y_q;
                                end
                                x_d = x_q + 11'd1;
                            end else begin
                                line_err_d = 1'b1;
                            end
                        end
                    end else if (href_dly_q) begin
                        if (phase_q || (x_q != COL_X)) line_err_d = 1'b1;
                        phase_d = 1'b0;
                        x_d     = '0;
                        if (y_q < ROW_Y) y_d = y_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pix_data    = pix_data_q;
    assign pix_wr      = pix_wr_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign line_err    = line_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_cmos_capture.sv
// Directed + randomized frames for cmos_capture, checked against a frame-level
// reference model that predicts the pixel writes and sticky flags per frame.
module tb_cmos_capture;

    localparam int COL  = 4;
    localparam int ROW  = 2;
    localparam int SKIP = 2;

    logic        clk = 1'b0;
    logic        rstn, vsyn, href, ff, en;
    logic [7:0]  data;
    logic [15:0] pix_data;
    logic        pix_wr;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        fs, fd, le, ov;

    always #5 clk = ~clk;

    cmos_capture #(.COL(COL), .ROW(ROW), .SKIP_FRAMES(SKIP)) dut (
        .CLK(clk), .RSTn(rstn), .cmos_vsyn(vsyn), .cmos_href(href),
        .cmos_data(data), .capture_en(en), .fifo_full(ff),
        .pix_data(pix_data), .pix_wr(pix_wr), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(fs), .frame_done(fd), .line_err(le), .overflow(ov)
    );

    int errors = 0;
    int checks = 0;

    // Monitor: collects committed writes and pulse counts.
    logic [36:0] got[$];
    int fs_cnt = 0, fd_cnt = 0, b2b = 0;
    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        if (pix_wr) got.push_back({pix_data, pix_x, pix_y});
        if (fs) fs_cnt++;
        if (fd) fd_cnt++;
        if (pix_wr && prev_wr) b2b++;
        prev_wr = pix_wr;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Stimulus description and model state.
    logic [7:0]  stim[3][12];
    bit          ffp[3][6];
    int          len[3];
    int          nl;
    bit          en_start, en_mid;
    logic [36:0] exp_q[$];
    bit          cap;
    int          skip_m = 0;
    bit          le_m = 0, ov_m = 0;
    int          gbase, fsb, fdb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input bit vs, input bit hr, input logic [7:0] d, input bit f);
        vsyn = vs; href = hr; data = d; ff = f;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lines(input int n, input int l0, input int l1, input int l2, input bit rnd);
        nl = n; len[0] = l0; len[1] = l1; len[2] = l2;
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 12; i++) stim[l][i] = rnd ? 8'($urandom) : 8'(i + 1);
            for (int p = 0; p < 6; p++) ffp[l][p] = 1'b0;
        end
    endtask

    // Reference model: whole-frame outcome from the framing rules.
    task automatic model_frame();
        int x, y;
        cap = 1'b0;
        exp_q.delete();
        if (skip_m < SKIP) begin
            skip_m++;
        end else if (en_start) begin
            cap = 1'b1; le_m = 1'b0; ov_m = 1'b0; y = 0;
            for (int l = 0; l < nl; l++) begin
                for (int p = 0; p < len[l] / 2; p++) begin
                    x = (p < COL) ? p : COL;
                    if (x < COL && y < ROW) begin
                        if (ffp[l][p]) ov_m = 1'b1;
                        else exp_q.push_back({stim[l][2*p], stim[l][2*p+1], 11'(x), 10'(y)});
                    end else begin
                        le_m = 1'b1;
                    end
                end
                if (len[l] % 2 != 0) le_m = 1'b1;
                if (len[l] / 2 < COL) le_m = 1'b1;
                y = (y < ROW) ? y + 1 : ROW;
            end
            if (y != ROW) le_m = 1'b1;
        end
    endtask

    task automatic drive_frame();
        bit ffn;
        en = en_start;
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0);
        for (int l = 0; l < nl; l++) begin
            ffn = 1'b0;
            for (int i = 0; i < len[l]; i++) begin
                cyc(0, 1, stim[l][i], ffn);
                ffn = (i % 2 == 1) ? ffp[l][i/2] : 1'b0;
            end
            cyc(0, 0, 8'h00, ffn);
            cyc(0, 0, 8'h00, 0);
            cyc(0, 0, 8'h00, 0);
            en = en_mid;
        end
        cyc(0, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 8'h00, 0);
    endtask

    task automatic run_frame(input string tag);
        int n;
        gbase = got.size(); fsb = fs_cnt; fdb = fd_cnt;
        model_frame();
        drive_frame();
        @(negedge clk);
        n = got.size() - gbase;
        chk($sformatf("%s_wr_count", tag), 64'(n), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < n; k++)
            chk($sformatf("%s_pix%0d", tag, k), 64'(got[gbase + k]), 64'(exp_q[k]));
        chk($sformatf("%s_frame_start", tag), 64'(fs_cnt - fsb), 64'(cap ? 1 : 0));
        chk($sformatf("%s_frame_done", tag), 64'(fd_cnt - fdb), 64'(cap ? 1 : 0));
        chk($sformatf("%s_line_err", tag), 64'(le), 64'(le_m));
        chk($sformatf("%s_overflow", tag), 64'(ov), 64'(ov_m));
    endtask

    initial begin
        rstn = 1'b0; vsyn = 1'b0; href = 1'b1; data = 8'h00; ff = 1'b0; en = 1'b1;

        // Reset asserted in the middle of an active frame.
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'($urandom), 0);
        chk("reset_outputs", 64'({pix_data, pix_wr, pix_x, pix_y, fs, fd, le, ov}), 64'd0);
        rstn = 1'b1;
        gbase = got.size();
        for (int i = 0; i < 6; i++) cyc(0, 1, 8'($urandom), 0);
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        chk("partial_frame_no_wr", 64'(got.size() - gbase), 64'd0);

        en_start = 1'b1; en_mid = 1'b1;
        set_lines(2, 8, 8, 0, 1); run_frame("skip1");
        set_lines(2, 8, 8, 0, 1); run_frame("skip2");
        set_lines(2, 8, 8, 0, 0); run_frame("basic");
        set_lines(2, 9, 10, 0, 1); run_frame("odd_long");
        set_lines(2, 8, 8, 0, 1); ffp[0][1] = 1'b1; run_frame("fifo_full");
        en_start = 1'b0; en_mid = 1'b1;
        set_lines(2, 8, 8, 0, 1); run_frame("en_low");
        en_start = 1'b1;
        set_lines(2, 8, 8, 0, 1); run_frame("en_back");

        for (int f = 0; f < 5; f++) begin
            set_lines(int'($urandom_range(1, 3)), int'($urandom_range(5, 11)),
                      int'($urandom_range(5, 11)), int'($urandom_range(5, 11)), 1);
            for (int l = 0; l < 3; l++)
                for (int p = 0; p < 6; p++) ffp[l][p] = ($urandom_range(0, 3) == 0);
            en_start = ($urandom_range(0, 3) != 0);
            en_mid = 1'(($urandom));
            run_frame($sformatf("rand%0d", f));
        end

        // Reset pulse mid-line inside a captured frame.
        en = 1'b1;
        set_lines(1, 8, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0);
        cyc(0, 1, stim[0][0], 0);
        cyc(0, 1, stim[0][1], 0);
        cyc(0, 1, stim[0][2], 1);
        cyc(0, 1, stim[0][3], 0);
        chk("ov_before_rst", 64'(ov), 64'd1);
        rstn = 1'b0;
        cyc(0, 1, stim[0][4], 0);
        rstn = 1'b1;
        chk("rst_midline_outputs", 64'({pix_data, pix_wr, pix_x, pix_y, fs, fd, le, ov}), 64'd0);
        gbase = got.size(); fdb = fd_cnt;
        for (int i = 5; i < 8; i++) cyc(0, 1, stim[0][i], 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 8'h00, 0);
        @(negedge clk);
        chk("rst_rest_no_wr", 64'(got.size() - gbase), 64'd0);
        chk("rst_rest_no_done", 64'(fd_cnt - fdb), 64'd0);
        skip_m = 0; le_m = 1'b0; ov_m = 1'b0;
        en_start = 1'b1; en_mid = 1'b1;
        set_lines(2, 8, 8, 0, 1); run_frame("post_rst_skip");

        chk("no_back_to_back", 64'(b2b), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
